audio_stream_ctrl: RTL and testbench
====================================

# audio_stream_ctrl

Frame-synchronous sequencer between the WM8731 sample FIFOs and the I2S serializer/deserializer. On every codec frame it pops one stereo word from the playback FIFO into the DAC serializer. It pushes each captured ADC word into the record FIFO. It never reads an empty FIFO or writes a full one, and it counts underruns and overruns in saturating counters.

## Interface
- B, 32, sample word width ({left[15:0], right[15:0]} at default)
- CW, 8, width of each error counter
- clk  in  1  system clock; all logic on rising edge
- reset  in  1  asynchronous, active-low reset
- enable  in  1  stream enable, sampled synchronously
- lrck  in  1  codec frame clock, already synchronized to clk; falling edge = frame start
- play_empty  in  1  playback FIFO empty flag
- play_data  in  B  playback FIFO head word (combinational read data)
- play_rd  out  1  playback FIFO pop strobe
- dac_word  out  B  word handed to DAC serializer
- dac_load  out  1  one-cycle strobe: dac_word valid
- adc_word  in  B  captured word from ADC deserializer
- adc_valid  in  1  one-cycle strobe, at most once per frame
- rec_full  in  1  record FIFO full flag
- rec_wr  out  1  record FIFO push strobe
- rec_data  out  B  record FIFO write data
- clr_cnt  in  1  synchronous clear of both counters
- underrun_cnt  out  CW  frames served with an empty playback FIFO
- overrun_cnt  out  CW  ADC words dropped on a full record FIFO

## Operation
- Edge detector: lrck_d is the registered lrck, reset to 0. fall = lrck_d & ~lrck. lrck_d updates regardless of enable. Reset never produces a spurious edge.
- Playback FSM states: IDLE, WAIT, FETCH, LOAD.
  - IDLE: enable=1 -> WAIT.
  - WAIT: enable=0 -> IDLE; else fall -> FETCH.
  - FETCH -> LOAD, unconditionally.
  - LOAD -> WAIT if enable, else IDLE.
- FETCH with play_empty=0: play_rd=1 and dac_word <= play_data.
- FETCH with play_empty=1: play_rd=0, dac_word <= 0, underrun_cnt increments.
- LOAD: dac_load=1 for one cycle.
- Frame edges arriving in FETCH/LOAD are ignored. lrck half-period must be ≥4 clk cycles.
- Disabling mid-frame: the current FETCH/LOAD completes, then the FSM goes to IDLE.
- Capture path, independent of the FSM: adc_valid & enable & ~rec_full -> next cycle rec_wr=1 with rec_data = adc_word registered.
- adc_valid & enable & rec_full -> word dropped, rec_wr stays 0, overrun_cnt increments.
- adc_valid with enable=0 is ignored.
- Counters saturate at 2^CW-1. clr_cnt has priority over a same-cycle increment, so the result is 0.
- Invariants: play_rd never high while play_empty=1; rec_wr never high on a cycle whose decision saw rec_full=1.

## Timing
- Reset values: state IDLE, lrck_d 0; play_rd, dac_load and rec_wr 0; dac_word and rec_data 0; both counters 0.
- Reset is asynchronous mid-operation: every register returns to its reset value immediately. A partially served frame is discarded, with no dac_load or rec_wr afterwards.
- Let t be the cycle in which fall=1 while in WAIT.
  - t+1 (FETCH): play_rd asserted combinationally from state and play_empty.
  - End of t+1: dac_word registered and underrun_cnt updated.
  - t+2 (LOAD): dac_load=1.
  - t+3: back in WAIT.
- Playback latency from frame edge to dac_load is 2 cycles.
- Capture: adc_valid in cycle c -> rec_wr/rec_data in c+1. Overrun_cnt updates at the end of c.
- play_rd, dac_load and rec_wr are single-cycle pulses.

## Structure
- Package audio_pkg: FSM state enum (IDLE, WAIT, FETCH, LOAD) and default word width constant 32.
- Sub-module sat_cnt (parameter CW; ports: inc, clr, count), instantiated twice for the two counters.
- Everything else sits in audio_stream_ctrl.

## Test plan
- Enable, FIFO holds 0xAAAA5555 then 0x12345678, two lrck falls: play_rd pulses once per frame; dac_load shows 0xAAAA5555 then 0x12345678, each 2 cycles after its edge; underrun_cnt=0.
- Empty playback FIFO, three frames: play_rd never asserted; dac_word=0 with three dac_load pulses; underrun_cnt=3.
- adc_valid with 0xCAFEF00D, rec_full=0 -> rec_wr=1 next cycle with rec_data=0xCAFEF00D. Repeat with rec_full=1 -> no rec_wr, overrun_cnt=1.
- CW=2: five overruns -> overrun_cnt saturates at 3. clr_cnt asserted together with an overrun -> count 0.
- Drop enable while in FETCH: LOAD still occurs, state returns to IDLE, and later lrck edges produce no play_rd.
- Assert reset during LOAD: all outputs 0 immediately. After release with lrck held low, no frame is served until the next lrck falling edge.

Source files
------------

// File: rtl/audio_pkg.sv
// Shared types and constants for the WM8731 audio stream sequencer.
package audio_pkg;

    localparam int WORD_W = 32;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        FETCH,
        LOAD
    } state_t;

endpackage

// File: rtl/audio_stream_ctrl_sat_cnt.sv
// Saturating event counter with a synchronous clear that beats a same-cycle increment.
module sat_cnt #(
    parameter int CW = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          inc,
    input  logic          clr,
    output logic [CW-1:0] count
);

    localparam logic [CW-1:0] MAX = '1;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && (count != MAX)) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/audio_stream_ctrl.sv
// Frame-synchronous sequencer between the WM8731 sample FIFOs and the I2S serializer/deserializer.
module audio_stream_ctrl
    import audio_pkg::*;
#(
    parameter int B  = WORD_W,
    parameter int CW = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          enable,
    input  logic          lrck,
    input  logic          play_empty,
    input  logic [B-1:0]  play_data,
    output logic          play_rd,
    output logic [B-1:0]  dac_word,
    output logic          dac_load,
    input  logic [B-1:0]  adc_word,
    input  logic          adc_valid,
    input  logic          rec_full,
    output logic          rec_wr,
    output logic [B-1:0]  rec_data,
    input  logic          clr_cnt,
    output logic [CW-1:0] underrun_cnt,
    output logic [CW-1:0] overrun_cnt
);

    state_t state;
    logic   lrck_d;
    logic   fall;
    logic   fetch;
    logic   underrun;
    logic   overrun;
    logic   rec_accept;

    assign fall       = lrck_d & ~lrck;
    assign fetch      = (state == FETCH);
    // Pop strobe is decoded from the current state so the FIFO head is consumed in the same cycle it is latched.
    assign play_rd    = fetch & ~play_empty;
    assign underrun   = fetch & play_empty;
    assign rec_accept = adc_valid & enable & ~rec_full;
    assign overrun    = adc_valid & enable & rec_full;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            lrck_d <= 1'b0;
        end else begin
            lrck_d <= lrck;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            dac_load <= 1'b0;
            dac_word <= '0;
        end else begin
            dac_load <= 1'b0;
            case (state)
                IDLE:  if (enable) state <= WAIT;
                WAIT: begin
                    if (!enable)   state <= IDLE;
                    else if (fall) state <= FETCH;
                end
                FETCH: begin
                    state    <= LOAD;
                    dac_load <= 1'b1;
                    dac_word <= play_empty ? '0 : play_data;
                end
                LOAD:    state <= enable ? WAIT : IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rec_wr   <= 1'b0;
            rec_data <= '0;
        end else begin
            rec_wr <= rec_accept;
            if (rec_accept) rec_data <= adc_word;
        end
    end

    sat_cnt #(.CW(CW)) u_underrun (
        .clk   (clk),
        .reset (reset),
        .inc   (underrun),
        .clr   (clr_cnt),
        .count (underrun_cnt)
    );

    sat_cnt #(.CW(CW)) u_overrun (
        .clk   (clk),
        .reset (reset),
        .inc   (overrun),
        .clr   (clr_cnt),
        .count (overrun_cnt)
    );

endmodule

// File: tb/tb_audio_stream_ctrl.sv
// Scoreboard bench for audio_stream_ctrl: directed scenarios followed by randomized frames.
module tb_audio_stream_ctrl;

    localparam int B    = 32;
    localparam int CW   = 2;
    localparam int CMAX = (1 << CW) - 1;

    typedef struct {
        logic [B-1:0] word;
        int           cyc;
    } exp_t;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          enable = 1'b0;
    logic          lrck = 1'b0;
    logic          play_empty = 1'b1;
    logic [B-1:0]  play_data = '0;
    logic          play_rd;
    logic [B-1:0]  dac_word;
    logic          dac_load;
    logic [B-1:0]  adc_word = '0;
    logic          adc_valid = 1'b0;
    logic          rec_full = 1'b0;
    logic          rec_wr;
    logic [B-1:0]  rec_data;
    logic          clr_cnt = 1'b0;
    logic [CW-1:0] underrun_cnt;
    logic [CW-1:0] overrun_cnt;

    // Shadow inputs, applied on the next falling clock edge.
    logic         s_rst = 1'b0;
    logic         s_en = 1'b0;
    logic         s_lrck = 1'b0;
    logic         s_av = 1'b0;
    logic [B-1:0] s_aw = '0;
    logic         s_rf = 1'b0;
    logic         s_clr = 1'b0;

    logic [B-1:0] play_q[$];
    exp_t         dac_q[$];
    exp_t         rec_q[$];

    int cyc = 0;
    int fetch_cyc = -100;
    bit prev_lrck = 1'b0;
    bit en_prev = 1'b0;
    int exp_under = 0;
    int exp_over = 0;
    int checks = 0;
    int failures = 0;

    audio_stream_ctrl #(.B(B), .CW(CW)) dut (
        .clk          (clk),
        .reset        (reset),
        .enable       (enable),
        .lrck         (lrck),
        .play_empty   (play_empty),
        .play_data    (play_data),
        .play_rd      (play_rd),
        .dac_word     (dac_word),
        .dac_load     (dac_load),
        .adc_word     (adc_word),
        .adc_valid    (adc_valid),
        .rec_full     (rec_full),
        .rec_wr       (rec_wr),
        .rec_data     (rec_data),
        .clr_cnt      (clr_cnt),
        .underrun_cnt (underrun_cnt),
        .overrun_cnt  (overrun_cnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [B-1:0] act, input logic [B-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    task automatic model_reset();
        exp_under = 0;
        exp_over  = 0;
        prev_lrck = 1'b0;
        en_prev   = 1'b0;
        fetch_cyc = -100;
        dac_q.delete();
        rec_q.delete();
    endtask

    // Frame rules: an lrck fall is served when enable was high in that cycle and the one
    // before and no frame is in flight; the FIFO head is fetched one cycle later and
    // presented two cycles after the edge.
    task automatic model_step();
        int           k;
        bit           fall;
        bit           inc_u;
        bit           inc_o;
        logic [B-1:0] w;
        k = cyc;
        if (!reset) begin
            model_reset();
            check("play_rd_in_reset", play_rd, 0);
            return;
        end
        inc_u = 0;
        inc_o = 0;
        fall  = prev_lrck && !lrck;
        check("play_rd", play_rd, (k == fetch_cyc) && !play_empty);
        if (play_rd && play_q.size() > 0) void'(play_q.pop_front());
        if (k == fetch_cyc && play_empty) inc_u = 1;
        if (fall && enable && en_prev && k != fetch_cyc && k != fetch_cyc + 1) begin
            fetch_cyc = k + 1;
            w = (play_q.size() > 0) ? play_q[0] : '0;
            dac_q.push_back('{w, k + 2});
        end
        if (adc_valid && enable) begin
            if (rec_full) inc_o = 1;
            else          rec_q.push_back('{adc_word, k + 1});
        end
        if (clr_cnt)                        exp_under = 0;
        else if (inc_u && exp_under < CMAX) exp_under++;
        if (clr_cnt)                        exp_over = 0;
        else if (inc_o && exp_over < CMAX)  exp_over++;
        prev_lrck = lrck;
        en_prev   = enable;
    endtask

    task automatic cycle();
        @(negedge clk);
        reset      = s_rst;
        enable     = s_en;
        lrck       = s_lrck;
        adc_valid  = s_av;
        adc_word   = s_aw;
        rec_full   = s_rf;
        clr_cnt    = s_clr;
        play_empty = (play_q.size() == 0);
        play_data  = play_empty ? B'($urandom()) : play_q[0];
        s_av       = 1'b0;
        s_clr      = 1'b0;
        #1;
        model_step();
    endtask

    task automatic half(input logic lvl, input int n);
        s_lrck = lvl;
        repeat (n) cycle();
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_play_rd"},  play_rd,      0);
        check({tag, "_dac_load"}, dac_load,     0);
        check({tag, "_dac_word"}, dac_word,     0);
        check({tag, "_rec_wr"},   rec_wr,       0);
        check({tag, "_rec_data"}, rec_data,     0);
        check({tag, "_underrun"}, underrun_cnt, 0);
        check({tag, "_overrun"},  overrun_cnt,  0);
    endtask

    task automatic rnd_ctl();
        if ($urandom_range(0, 15) == 0) s_en = ~s_en;
        if ($urandom_range(0, 24) == 0) s_clr = 1'b1;
        s_rf = ($urandom_range(0, 2) == 0);
    endtask

    // Monitor: compares registered outputs against the scoreboard queues each cycle.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            check("dac_load", dac_load, dac_q.size() > 0 && dac_q[0].cyc == cyc);
            if (dac_load && dac_q.size() > 0 && dac_q[0].cyc == cyc) begin
                e = dac_q.pop_front();
                check("dac_word", dac_word, e.word);
            end
            while (dac_q.size() > 0 && dac_q[0].cyc <= cyc) void'(dac_q.pop_front());
            check("rec_wr", rec_wr, rec_q.size() > 0 && rec_q[0].cyc == cyc);
            if (rec_wr && rec_q.size() > 0 && rec_q[0].cyc == cyc) begin
                e = rec_q.pop_front();
                check("rec_data", rec_data, e.word);
            end
            while (rec_q.size() > 0 && rec_q[0].cyc <= cyc) void'(rec_q.pop_front());
            check("underrun_cnt", underrun_cnt, exp_under);
            check("overrun_cnt",  overrun_cnt,  exp_over);
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        repeat (3) cycle();
        check_reset_outputs("reset");
        s_rst  = 1'b1;
        s_lrck = 1'b1;
        repeat (2) cycle();

        // Two buffered words over two frames.
        play_q.push_back(32'hAAAA_5555);
        play_q.push_back(32'h1234_5678);
        s_en = 1'b1;
        repeat (2) cycle();
        half(0, 5); half(1, 5); half(0, 5); half(1, 5);
        check("fifo_drained", play_q.size(), 0);
        check("underrun_after_play", underrun_cnt, 0);

        // Empty playback FIFO for three frames.
        repeat (3) begin half(0, 5); half(1, 5); end
        check("underrun_three", underrun_cnt, 3);

        // Capture accept, then a drop on a full record FIFO.
        s_clr = 1'b1;
        cycle();
        s_av = 1'b1; s_aw = 32'hCAFE_F00D; s_rf = 1'b0;
        cycle(); cycle();
        s_av = 1'b1; s_aw = 32'h0BAD_BEEF; s_rf = 1'b1;
        cycle();
        s_rf = 1'b0;
        cycle();
        check("overrun_one", overrun_cnt, 1);

        // Saturation, then clear colliding with an overrun.
        s_rf = 1'b1;
        repeat (5) begin s_av = 1'b1; s_aw = B'($urandom()); cycle(); end
        s_rf = 1'b0;
        cycle();
        check("overrun_saturated", overrun_cnt, CMAX);
        s_av = 1'b1; s_rf = 1'b1; s_clr = 1'b1;
        cycle();
        s_rf = 1'b0;
        cycle();
        check("overrun_clr_priority", overrun_cnt, 0);

        // Drop enable while the frame is in FETCH.
        play_q.push_back(32'h0123_4567);
        play_q.push_back(32'h89AB_CDEF);
        half(1, 3);
        s_lrck = 1'b0;
        cycle();
        s_en = 1'b0;
        repeat (4) cycle();
        half(1, 5); half(0, 5); half(1, 5); half(0, 5);
        check("fifo_left_after_disable", play_q.size(), 1);
        play_q.delete();

        // Asynchronous reset during LOAD with a capture pending.
        s_en = 1'b1;
        half(1, 4);
        s_lrck = 1'b0;
        cycle(); cycle();
        s_av = 1'b1; s_aw = 32'h5A5A_A5A5; s_rf = 1'b0;
        cycle();
        #2;
        s_rst = 1'b0;
        reset = 1'b0;
        #1;
        check_reset_outputs("async_reset");
        model_reset();
        repeat (3) cycle();
        s_rst = 1'b1;
        repeat (6) cycle();
        play_q.push_back(32'hFEED_0001);
        half(1, 5); half(0, 5); half(1, 4);
        check("frame_after_reset", play_q.size(), 0);

        // Randomized frames.
        for (int f = 0; f < 40; f++) begin
            int hp;
            hp = $urandom_range(4, 7);
            s_lrck = 1'b0;
            for (int i = 0; i < hp; i++) begin rnd_ctl(); cycle(); end
            hp = $urandom_range(4, 7);
            s_lrck = 1'b1;
            for (int i = 0; i < hp; i++) begin
                rnd_ctl();
                if (i == 0) begin
                    repeat ($urandom_range(0, 2)) if (play_q.size() < 4) play_q.push_back(B'($urandom()));
                    if ($urandom_range(0, 3) != 0) begin s_av = 1'b1; s_aw = B'($urandom()); end
                end
                cycle();
            end
        end

        s_en = 1'b0;
        s_rf = 1'b0;
        repeat (8) cycle();
        check("dac_pending", dac_q.size(), 0);
        check("rec_pending", rec_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
